// File: rtl/piece_lock.sv
// piece_lock: writes the four cells of a landed tetromino into board RAM,
// one cell every three cycles, then raises o_complete until i_enable falls.
// Also reports top-out (a cell written into the hidden spawn rows) and
// out-of-board cells or an invalid piece type.
//
// Ports:
//   i_clk, i_resetn    clock, asynchronous active-low reset
//   i_enable           level; high = run/hold result, low = return to idle
//   i_piece_type       0=I 1=O 2=T 3=S 4=Z 5=J 6=L, 7=invalid
//   i_piece_rot        clockwise rotation 0..3
//   i_piece_x/_y       bounding-box left column / top row
//   i_piece_colour     value written to each cell
//   o_ram_addr/_data   board RAM address / write data
//   o_ram_wren         board RAM write enable (one cycle per in-range cell)
//   o_complete         all four cells processed
//   o_top_out          a written cell landed in the hidden rows
//   o_oob              a cell was skipped, or the piece type was invalid
//
// state     | meaning
// IDLE      | outputs at 0, waiting for enable
// LATCH     | capture piece inputs, clear flags
// ADDR      | present address/data for the current cell
// WRITE     | pulse write enable if the cell is on the board
// WRITE_END | drop write enable, advance to next cell or finish
// DONE      | hold complete/top_out/oob until enable falls
module piece_lock #(
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 25,
    parameter int HIDDEN_ROWS = 4
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_enable,
    input  logic [2:0] i_piece_type,
    input  logic [1:0] i_piece_rot,
    input  logic [3:0] i_piece_x,
    input  logic [4:0] i_piece_y,
    input  logic [5:0] i_piece_colour,
    output logic [7:0] o_ram_addr,
    output logic [5:0] o_ram_data,
    output logic       o_ram_wren,
    output logic       o_complete,
    output logic       o_top_out,
    output logic       o_oob
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LATCH     = 3'd1;
    localparam logic [2:0] S_ADDR      = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WRITE_END = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // Four cells packed cell0 in [15:12] down to cell3 in [3:0]; each cell is
    // {dx[1:0], dy[1:0]}, listed in row-major order (dy first, then dx).
    function automatic logic [15:0] shape_cells(input logic [2:0] ptype,
                                                input logic [1:0] rot);
        logic [15:0] cells;
        cells = 16'h0000;
        case (ptype)
            3'd0: case (rot)
                2'd0: cells = 16'b00_01_01_01_10_01_11_01;
                2'd1: cells = 16'b10_00_10_01_10_10_10_11;
                2'd2: cells = 16'b00_10_01_10_10_10_11_10;
                2'd3: cells = 16'b01_00_01_01_01_10_01_11;
            endcase
            3'd1: cells = 16'b01_00_10_00_01_01_10_01;
            3'd2: case (rot)
                2'd0: cells = 16'b01_00_00_01_01_01_10_01;
                2'd1: cells = 16'b01_00_01_01_10_01_01_10;
                2'd2: cells = 16'b00_01_01_01_10_01_01_10;
                2'd3: cells = 16'b01_00_00_01_01_01_01_10;
            endcase
            3'd3: case (rot)
                2'd0: cells = 16'b01_00_10_00_00_01_01_01;
                2'd1: cells = 16'b01_00_01_01_10_01_10_10;
                2'd2: cells = 16'b01_01_10_01_00_10_01_10;
                2'd3: cells = 16'b00_00_00_01_01_01_01_10;
            endcase
            3'd4: case (rot)
                2'd0: cells = 16'b00_00_01_00_01_01_10_01;
                2'd1: cells = 16'b10_00_01_01_10_01_01_10;
                2'd2: cells = 16'b00_01_01_01_01_10_10_10;
                2'd3: cells = 16'b01_00_00_01_01_01_00_10;
            endcase
            3'd5: case (rot)
                2'd0: cells = 16'b00_00_00_01_01_01_10_01;
                2'd1: cells = 16'b01_00_10_00_01_01_01_10;
                2'd2: cells = 16'b00_01_01_01_10_01_10_10;
                2'd3: cells = 16'b01_00_01_01_00_10_01_10;
            endcase
            3'd6: case (rot)
                2'd0: cells = 16'b10_00_00_01_01_01_10_01;
                2'd1: cells = 16'b01_00_01_01_01_10_10_10;
                2'd2: cells = 16'b00_01_01_01_10_01_00_10;
                2'd3: cells = 16'b00_00_01_00_01_01_01_10;
            endcase
            default: cells = 16'h0000;
        endcase
        return cells;
    endfunction

    logic [2:0]  r_state;
    logic [1:0]  r_cell;
    logic [2:0]  r_type;
    logic [1:0]  r_rot;
    logic [3:0]  r_x;
    logic [4:0]  r_y;
    logic [5:0]  r_colour;

    logic [15:0] w_shape;
    logic [3:0]  w_cell;
    logic [5:0]  w_x;
    logic [5:0]  w_y;
    logic        w_in_range;
    logic        w_hidden;
    logic [7:0]  w_addr;

    assign w_shape = shape_cells(r_type, r_rot);
    // ~r_cell == 3 - r_cell, so cell 0 selects the top nibble
    assign w_cell  = w_shape[{~r_cell, 2'b00} +: 4];
    // 6-bit sums so an off-board cell can never wrap back onto the board
    assign w_x        = {2'b00, r_x} + {4'b0000, w_cell[3:2]};
    assign w_y        = {1'b0, r_y} + {4'b0000, w_cell[1:0]};
    assign w_in_range = (r_type != 3'd7) && (w_x < 6'(BOARD_W)) && (w_y < 6'(BOARD_H));
    assign w_hidden   = w_y < 6'(HIDDEN_ROWS);
    assign w_addr     = 8'(w_y) * 8'(BOARD_W) + 8'(w_x);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= S_IDLE;
            r_cell     <= 2'd0;
            r_type     <= 3'd0;
            r_rot      <= 2'd0;
            r_x        <= 4'd0;
            r_y        <= 5'd0;
            r_colour   <= 6'd0;
            o_ram_addr <= 8'd0;
            o_ram_data <= 6'd0;
            o_ram_wren <= 1'b0;
            o_complete <= 1'b0;
            o_top_out  <= 1'b0;
            o_oob      <= 1'b0;
        end else if (!i_enable) begin
            r_state    <= S_IDLE;
            r_cell     <= 2'd0;
            o_ram_addr <= 8'd0;
            o_ram_data <= 6'd0;
            o_ram_wren <= 1'b0;
            o_complete <= 1'b0;
            o_top_out  <= 1'b0;
            o_oob      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_LATCH;
                S_LATCH: begin
                    r_type    <= i_piece_type;
                    r_rot     <= i_piece_rot;
                    r_x       <= i_piece_x;
                    r_y       <= i_piece_y;
                    r_colour  <= i_piece_colour;
                    r_cell    <= 2'd0;
                    o_top_out <= 1'b0;
                    o_oob     <= 1'b0;
                    r_state   <= S_ADDR;
                end
                S_ADDR: begin
                    o_ram_addr <= w_addr;
                    o_ram_data <= r_colour;
                    o_ram_wren <= 1'b0;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    o_ram_wren <= w_in_range;
                    if (!w_in_range) begin
                        o_oob <= 1'b1;
                    end else if (w_hidden) begin
                        o_top_out <= 1'b1;
                    end
                    r_state <= S_WRITE_END;
                end
                S_WRITE_END: begin
                    o_ram_wren <= 1'b0;
                    if (r_cell == 2'd3) begin
                        o_complete <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cell  <= r_cell + 2'd1;
                        r_state <= S_ADDR;
                    end
                end
                S_DONE: r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_lock.sv
module tb_piece_lock;

    logic       clk;
    logic       rst_n;
    logic       i_enable;
    logic [2:0] i_piece_type;
    logic [1:0] i_piece_rot;
    logic [3:0] i_piece_x;
    logic [4:0] i_piece_y;
    logic [5:0] i_piece_colour;
    logic [7:0] o_ram_addr;
    logic [5:0] o_ram_data;
    logic       o_ram_wren;
    logic       o_complete;
    logic       o_top_out;
    logic       o_oob;

    int checks   = 0;
    int failures = 0;
    int wr_q[$];

    piece_lock dut (
        .i_clk          (clk),
        .i_resetn       (rst_n),
        .i_enable       (i_enable),
        .i_piece_type   (i_piece_type),
        .i_piece_rot    (i_piece_rot),
        .i_piece_x      (i_piece_x),
        .i_piece_y      (i_piece_y),
        .i_piece_colour (i_piece_colour),
        .o_ram_addr     (o_ram_addr),
        .o_ram_data     (o_ram_data),
        .o_ram_wren     (o_ram_wren),
        .o_complete     (o_complete),
        .o_top_out      (o_top_out),
        .o_oob          (o_oob)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Row-major index (dy*4+dx) of cell idx: SRS spawn shape rotated
    // clockwise r times inside its box, O never moves.
    function automatic int cell_key(input int t, input int r, input int idx);
        logic [15:0] m, nm;
        int n, cnt, res;
        case (t)
            0: m = 16'h00F0;
            1: m = 16'h0066;
            2: m = 16'h0072;
            3: m = 16'h0036;
            4: m = 16'h0063;
            5: m = 16'h0071;
            6: m = 16'h0074;
            default: m = 16'h0000;
        endcase
        n = (t == 0) ? 4 : 3;
        if (t != 1) begin
            for (int k = 0; k < r; k++) begin
                nm = '0;
                for (int y = 0; y < 4; y++)
                    for (int x = 0; x < 4; x++)
                        if (m[y*4+x]) nm[x*4 + (n-1-y)] = 1'b1;
                m = nm;
            end
        end
        cnt = 0;
        res = 0;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) begin
                if (cnt == idx) res = b;
                cnt++;
            end
        end
        return res;
    endfunction

    // Model: m_k = edges since enable was first sampled high (0 = idle).
    int m_k;
    int m_type, m_rot, m_px, m_py, m_col;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0;
        end else if (!i_enable) begin
            m_k <= 0;
        end else begin
            if (m_k < 100) m_k <= m_k + 1;
            if (m_k == 1) begin
                m_type <= int'(i_piece_type);
                m_rot  <= int'(i_piece_rot);
                m_px   <= int'(i_piece_x);
                m_py   <= int'(i_piece_y);
                m_col  <= int'(i_piece_colour);
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit e_wren, e_top, e_oob, inr;
        int key, cx, cy, ke;
        if (rst_n) begin
            e_wren = 0; e_top = 0; e_oob = 0;
            for (int i = 0; i < 4; i++) begin
                key = cell_key(m_type, m_rot, i);
                cx  = m_px + key % 4;
                cy  = m_py + key / 4;
                inr = (m_type != 7) && (cx < 10) && (cy < 25);
                ke  = 4 + 3*i;
                if (m_k == ke && inr) e_wren = 1;
                if (m_k >= ke) begin
                    if (!inr) e_oob = 1;
                    else if (cy < 4) e_top = 1;
                end
                if ((m_k == ke - 1 || m_k == ke) && inr) begin
                    chk("ram_addr", int'(o_ram_addr), cy*10 + cx);
                    chk("ram_data", int'(o_ram_data), m_col);
                end
            end
            if (m_k < 3) begin
                chk("idle_addr", int'(o_ram_addr), 0);
                chk("idle_data", int'(o_ram_data), 0);
            end
            chk("ram_wren", int'(o_ram_wren), int'(e_wren));
            chk("complete", int'(o_complete), (m_k >= 14) ? 1 : 0);
            chk("top_out", int'(o_top_out), int'(e_top));
            chk("oob", int'(o_oob), int'(e_oob));
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_ram_wren) wr_q.push_back(int'(o_ram_addr));
    end

    // All stimulus tasks start and end at posedge+2.
    task automatic start_piece(input int t, input int r, input int x, input int y, input int c);
        i_piece_type   = 3'(t);
        i_piece_rot    = 2'(r);
        i_piece_x      = 4'(x);
        i_piece_y      = 5'(y);
        i_piece_colour = 6'(c);
        i_enable       = 1'b1;
    endtask

    task automatic wait_complete(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!o_complete && n < 40);
        #1;
    endtask

    task automatic stop_piece();
        i_enable = 1'b0;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_writes(input string nm, input int n, input int e0, input int e1,
                              input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, wr_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < wr_q.size()) chk({nm, "_addr"}, wr_q[i], e[i]);
    endtask

    initial begin
        int n, d;
        rst_n = 1'b0;
        i_enable = 1'b0;
        i_piece_type = '0; i_piece_rot = '0; i_piece_x = '0; i_piece_y = '0;
        i_piece_colour = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", int'({o_ram_addr, o_ram_data, o_ram_wren, o_complete, o_top_out, o_oob}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // O at the bottom of the board
        wr_q.delete();
        start_piece(1, 0, 4, 23, 5);
        wait_complete(n);
        chk("o_latency", n, 14);
        chk_writes("o_piece", 4, 235, 236, 245, 246);
        chk("o_top_out", int'(o_top_out), 0);
        chk("o_oob", int'(o_oob), 0);
        stop_piece();

        // I in the hidden rows
        wr_q.delete();
        start_piece(0, 0, 0, 2, 3);
        wait_complete(n);
        chk("i_latency", n, 14);
        chk_writes("i_piece", 4, 30, 31, 32, 33);
        chk("i_top_out", int'(o_top_out), 1);
        chk("i_oob", int'(o_oob), 0);
        stop_piece();

        // T hanging off the right edge
        wr_q.delete();
        start_piece(2, 0, 8, 10, 7);
        wait_complete(n);
        chk("t_latency", n, 14);
        chk_writes("t_piece", 3, 109, 118, 119, 0);
        chk("t_oob", int'(o_oob), 1);
        stop_piece();

        // invalid type
        wr_q.delete();
        start_piece(7, 0, 3, 3, 1);
        wait_complete(n);
        chk("inv_latency", n, 14);
        chk_writes("inv_piece", 0, 0, 0, 0, 0);
        chk("inv_oob", int'(o_oob), 1);
        stop_piece();

        // abort mid-sequence, then restart with new inputs
        start_piece(2, 0, 3, 5, 2);
        repeat (5) @(posedge clk);
        #2;
        i_enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wren", int'(o_ram_wren), 0);
        chk("abort_complete", int'(o_complete), 0);
        #1;
        wr_q.delete();
        start_piece(3, 1, 3, 5, 9);
        wait_complete(n);
        chk("restart_latency", n, 14);
        chk_writes("restart_piece", 4, 54, 64, 65, 75);
        stop_piece();

        // asynchronous reset while writing
        start_piece(0, 0, 0, 2, 3);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!o_ram_wren && n < 20);
        chk("wren_seen", int'(o_ram_wren), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({o_ram_addr, o_ram_data, o_ram_wren, o_complete, o_top_out, o_oob}), 0);
        i_enable = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        // randomized pieces, some aborted, inputs scrambled after latching
        for (int it = 0; it < 60; it++) begin
            start_piece($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15),
                        $urandom_range(0, 31), $urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom_range(1, 15);
                repeat (d) @(posedge clk);
                #2;
                stop_piece();
            end else begin
                repeat (4) @(posedge clk);
                #2;
                i_piece_type   = 3'($urandom_range(0, 7));
                i_piece_rot    = 2'($urandom_range(0, 3));
                i_piece_x      = 4'($urandom_range(0, 15));
                i_piece_y      = 5'($urandom_range(0, 31));
                i_piece_colour = 6'($urandom_range(0, 63));
                wait_complete(n);
                chk("rand_latency", n + 4, 14);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #2;
                stop_piece();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
